// File: rtl/multi_run_pkg.sv
// multi_run_pkg: shared types and elaboration helpers for multi_run_detector.
// Optional feature macro used by the design files: MULTI_RUN_RISE_PULSE_EN.
package multi_run_pkg;

  // Per-channel detector state. 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    ACTIVE = 2'b10
  } run_state_e;

  localparam int MIN_NCH = 1;
  localparam int MAX_NCH = 16;

  // The counted path needs THRESH-1 to fit in the run counter, and THRESH
  // of zero would make the counted path meaningless.
  function automatic bit thresh_in_range(input int thresh, input int cnt_w);
    return (thresh >= 1) && (thresh <= ((1 << cnt_w) - 1));
  endfunction

endpackage

// File: rtl/run_channel_fsm.sv
// run_channel_fsm: one channel of the multi-run detector. Holds the state
// register, the run counter, the registered detect output and, when
// MULTI_RUN_RISE_PULSE_EN is defined, a one-cycle pulse on ACTIVE entry.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_x low (or just cleared); cnt = 0, out_z = 0
// COUNT  | counted path, cnt qualifying edges seen so far (< THRESH)
// ACTIVE | run qualified; out_z = 1 until in_x drops
module run_channel_fsm
  import multi_run_pkg::*;
#(
  parameter int CNT_W  = 3,
  parameter int THRESH = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clear,
  input  logic in_x,
  input  logic in_y,
  output logic out_z
`ifdef MULTI_RUN_RISE_PULSE_EN
  ,
  output logic out_rise
`endif
);

  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(THRESH - 1);

  run_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_z;
`ifdef MULTI_RUN_RISE_PULSE_EN
  logic             r_rise;
`endif

  // Moore FSM: state, counter and registered outputs updated together.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out_z <= 1'b0;
`ifdef MULTI_RUN_RISE_PULSE_EN
      r_rise  <= 1'b0;
`endif
    end else if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out_z <= 1'b0;
`ifdef MULTI_RUN_RISE_PULSE_EN
      r_rise  <= 1'b0;
`endif
    end else begin
`ifdef MULTI_RUN_RISE_PULSE_EN
      r_rise <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (in_x) begin
            // THRESH of one makes the counted path as fast as the fast path.
            if (!in_y || (THRESH == 1)) begin
              r_state <= ACTIVE;
              r_cnt   <= in_y ? LP_ONE : '0;
              r_out_z <= 1'b1;
`ifdef MULTI_RUN_RISE_PULSE_EN
              r_rise  <= 1'b1;
`endif
            end else begin
              r_state <= COUNT;
              r_cnt   <= LP_ONE;
            end
          end
        end
        COUNT: begin
          if (!in_x) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= ACTIVE;
            r_out_z <= 1'b1;
`ifdef MULTI_RUN_RISE_PULSE_EN
            r_rise  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        ACTIVE: begin
          // Counter is frozen while ACTIVE so it can never wrap.
          if (!in_x) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out_z <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_out_z <= 1'b0;
        end
      endcase
    end
  end

  assign out_z = r_out_z;
`ifdef MULTI_RUN_RISE_PULSE_EN
  assign out_rise = r_rise;
`endif

endmodule

// File: rtl/multi_run_detector.sv
// multi_run_detector: NCH independent run detectors with a shared
// synchronous clear and an aggregated out_any flag.
// Optional feature: MULTI_RUN_RISE_PULSE_EN adds the out_rise entry pulses.
module multi_run_detector
  import multi_run_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CNT_W  = 3,
  parameter int THRESH = 2
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           clear,
  input  logic [NCH-1:0] in_x,
  input  logic [NCH-1:0] in_y,
  output logic [NCH-1:0] out_z,
  output logic           out_any
`ifdef MULTI_RUN_RISE_PULSE_EN
  ,
  output logic [NCH-1:0] out_rise
`endif
);

  // Reject configurations the counter or channel fan-out cannot support.
  if (!thresh_in_range(THRESH, CNT_W)) begin : g_bad_thresh
    $fatal(1, "multi_run_detector: THRESH=%0d outside 1..2^CNT_W-1", THRESH);
  end
  if ((NCH < MIN_NCH) || (NCH > MAX_NCH)) begin : g_bad_nch
    $fatal(1, "multi_run_detector: NCH=%0d outside supported range", NCH);
  end

  logic w_clear;
  assign w_clear = clear;

  // One detector per channel; channels share only clock, reset and clear.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    run_channel_fsm #(
      .CNT_W (CNT_W),
      .THRESH(THRESH)
    ) u_ch (
      .clk     (clk),
      .reset_b (reset_b),
      .clear   (w_clear),
      .in_x    (in_x[g]),
      .in_y    (in_y[g]),
      .out_z   (out_z[g])
`ifdef MULTI_RUN_RISE_PULSE_EN
      ,
      .out_rise(out_rise[g])
`endif
    );
  end

  // Aggregate flag is derived purely from registered channel outputs.
  assign out_any = |out_z;

endmodule

// File: tb/tb_multi_run_detector.sv
// tb_multi_run_detector: three detector instances (THRESH 2, 5, 3) share one
// stimulus stream and are compared against a run-length reference model.
// MULTI_RUN_RISE_PULSE_EN enables checking of out_rise.
module tb_multi_run_detector;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset_b = 1'b0;
  logic           clear = 1'b0;
  logic [NCH-1:0] in_x = '0;
  logic [NCH-1:0] in_y = '0;

  logic [NCH-1:0] z_o    [3];
  logic           any_o  [3];
`ifdef MULTI_RUN_RISE_PULSE_EN
  logic [NCH-1:0] rise_o [3];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: length of the current in_x-high run per channel and
  // which path the run started on. Detect = fast run, or run >= THRESH.
  int             run_len   [NCH];
  bit             fast_path [NCH];
  logic [NCH-1:0] prev_z    [3];

  always #5 clk = ~clk;

  multi_run_detector #(.NCH(NCH), .CNT_W(3), .THRESH(2)) u_dut2 (
    .clk(clk), .reset_b(reset_b), .clear(clear), .in_x(in_x), .in_y(in_y),
    .out_z(z_o[0]), .out_any(any_o[0])
`ifdef MULTI_RUN_RISE_PULSE_EN
    , .out_rise(rise_o[0])
`endif
  );

  multi_run_detector #(.NCH(NCH), .CNT_W(3), .THRESH(5)) u_dut5 (
    .clk(clk), .reset_b(reset_b), .clear(clear), .in_x(in_x), .in_y(in_y),
    .out_z(z_o[1]), .out_any(any_o[1])
`ifdef MULTI_RUN_RISE_PULSE_EN
    , .out_rise(rise_o[1])
`endif
  );

  multi_run_detector #(.NCH(NCH), .CNT_W(3), .THRESH(3)) u_dut3 (
    .clk(clk), .reset_b(reset_b), .clear(clear), .in_x(in_x), .in_y(in_y),
    .out_z(z_o[2]), .out_any(any_o[2])
`ifdef MULTI_RUN_RISE_PULSE_EN
    , .out_rise(rise_o[2])
`endif
  );

  function automatic int th_of(input int d);
    case (d)
      0:       return 2;
      1:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [NCH-1:0] exp_z(input int d);
    logic [NCH-1:0] e;
    e = '0;
    for (int ch = 0; ch < NCH; ch++)
      e[ch] = (run_len[ch] >= 1) && (fast_path[ch] || (run_len[ch] >= th_of(d)));
    return e;
  endfunction

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) prev_z[d] = exp_z(d);
    for (int ch = 0; ch < NCH; ch++) begin
      if (!reset_b || clear || !in_x[ch]) begin
        run_len[ch] = 0;
      end else begin
        if (run_len[ch] == 0) fast_path[ch] = !in_y[ch];
        if (run_len[ch] < 1000) run_len[ch] = run_len[ch] + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; clear = 1'b0; in_x = 4'hF; in_y = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (z_o[d] !== 4'h0) begin
        n_errors++; $display("FAIL reset_out_z dut%0d: got %h expected 0", d, z_o[d]);
      end
      n_checks++;
      if (any_o[d] !== 1'b0) begin
        n_errors++; $display("FAIL reset_out_any dut%0d: got %b expected 0", d, any_o[d]);
      end
`ifdef MULTI_RUN_RISE_PULSE_EN
      n_checks++;
      if (rise_o[d] !== 4'h0) begin
        n_errors++; $display("FAIL reset_out_rise dut%0d: got %h expected 0", d, rise_o[d]);
      end
`endif
    end
    reset_b = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (z_o[d] !== 4'hF) begin
        n_errors++; $display("FAIL reset_fast_entry dut%0d: got %h expected F", d, z_o[d]);
      end
      n_checks++;
      if (z_o[d] !== exp_z(d)) begin
        n_errors++; $display("FAIL reset_model dut%0d: got %h expected %h", d, z_o[d], exp_z(d));
      end
    end
  endtask

  task automatic test_counted_path();
    in_x = 4'h0; in_y = 4'h0;
    tick();
    in_x = 4'b0001; in_y = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (z_o[d][0] !== logic'(e >= th_of(d))) begin
          n_errors++;
          $display("FAIL counted_edge dut%0d edge %0d: got %b expected %b",
                   d, e, z_o[d][0], e >= th_of(d));
        end
        n_checks++;
        if (z_o[d] !== exp_z(d)) begin
          n_errors++; $display("FAIL counted_model dut%0d: got %h expected %h", d, z_o[d], exp_z(d));
        end
      end
    end
  endtask

  task automatic test_broken_run();
    in_x = 4'h0; in_y = 4'h0;
    tick();
    in_x = 4'b0001; in_y = 4'b0001;
    tick();
    in_x = 4'b0000;
    tick();
    n_checks++;
    if (z_o[2][0] !== 1'b0) begin
      n_errors++; $display("FAIL broken_idle dut3: got %b expected 0", z_o[2][0]);
    end
    in_x = 4'b0001;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (z_o[2][0] !== logic'(e >= 3)) begin
        n_errors++;
        $display("FAIL broken_fresh_run edge %0d: got %b expected %b", e, z_o[2][0], e >= 3);
      end
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (z_o[d] !== exp_z(d)) begin
          n_errors++; $display("FAIL broken_model dut%0d: got %h expected %h", d, z_o[d], exp_z(d));
        end
      end
    end
  endtask

  task automatic test_clear();
    in_x = 4'h0; in_y = 4'h0;
    tick();
    in_x = 4'b0010; in_y = 4'b0000;
    tick();
    in_x = 4'b0110; in_y = 4'b0100;
    tick();
    n_checks++;
    if (z_o[0] !== 4'b0010) begin
      n_errors++; $display("FAIL clear_setup dut2: got %h expected 2", z_o[0]);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (z_o[d] !== 4'h0 || any_o[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL clear_idle dut%0d: got z=%h any=%b expected z=0 any=0", d, z_o[d], any_o[d]);
      end
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (z_o[d] !== {1'b0, logic'(e >= th_of(d)), 2'b10}) begin
          n_errors++;
          $display("FAIL clear_rerun dut%0d edge %0d: got %h expected %h",
                   d, e, z_o[d], {1'b0, logic'(e >= th_of(d)), 2'b10});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    in_x = 4'h0; in_y = 4'h0;
    tick();
    in_x = 4'b0011; in_y = 4'b0001;
    tick();
    tick();
    #2 reset_b = 1'b0;
    #1;
    for (int ch = 0; ch < NCH; ch++) run_len[ch] = 0;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (z_o[d] !== 4'h0 || any_o[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL async_reset dut%0d: got z=%h any=%b expected z=0 any=0", d, z_o[d], any_o[d]);
      end
    end
    #1 reset_b = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (z_o[1][1:0] !== {1'b1, logic'(e >= 5)}) begin
        n_errors++;
        $display("FAIL async_restart dut5 edge %0d: got %b expected %b",
                 e, z_o[1][1:0], {1'b1, logic'(e >= 5)});
      end
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (z_o[d] !== exp_z(d)) begin
          n_errors++; $display("FAIL async_model dut%0d: got %h expected %h", d, z_o[d], exp_z(d));
        end
      end
    end
  endtask

  task automatic test_rise_hold();
    in_x = 4'h0; in_y = 4'h0;
    tick();
    in_x = 4'b1000;
    for (int c = 0; c <= 10; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (z_o[d] !== 4'b1000) begin
          n_errors++; $display("FAIL hold_out_z dut%0d cycle %0d: got %h expected 8", d, c, z_o[d]);
        end
`ifdef MULTI_RUN_RISE_PULSE_EN
        n_checks++;
        if (rise_o[d] !== ((c == 0) ? 4'b1000 : 4'b0000)) begin
          n_errors++;
          $display("FAIL rise_pulse dut%0d cycle %0d: got %h expected %h",
                   d, c, rise_o[d], (c == 0) ? 4'b1000 : 4'b0000);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_x  = 4'($urandom) | 4'($urandom);
      in_y  = 4'($urandom);
      clear = ($urandom_range(0, 24) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (z_o[d] !== exp_z(d)) begin
          n_errors++; $display("FAIL random_out_z dut%0d cycle %0d: got %h expected %h", d, c, z_o[d], exp_z(d));
        end
        n_checks++;
        if (any_o[d] !== (|exp_z(d))) begin
          n_errors++; $display("FAIL random_out_any dut%0d cycle %0d: got %b expected %b", d, c, any_o[d], |exp_z(d));
        end
`ifdef MULTI_RUN_RISE_PULSE_EN
        n_checks++;
        if (rise_o[d] !== (exp_z(d) & ~prev_z[d])) begin
          n_errors++;
          $display("FAIL random_out_rise dut%0d cycle %0d: got %h expected %h",
                   d, c, rise_o[d], exp_z(d) & ~prev_z[d]);
        end
`endif
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      run_len[ch] = 0;
      fast_path[ch] = 1'b0;
    end
    for (int d = 0; d < 3; d++) prev_z[d] = '0;
    test_reset();
    test_counted_path();
    test_broken_run();
    test_clear();
    test_async_reset();
    test_rise_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
